// File: rtl/hash_nonce_ctrl_pkg.sv
// Shared constants and state encoding for the nonce-search controller family.
package hash_nonce_ctrl_pkg;

  localparam int BYTE_BITS     = 8;
  localparam int NONCE_BYTES   = 4;
  localparam int PAYLOAD_BYTES = 12;
  localparam int DIGEST_BYTES  = 3;
  localparam int DEF_TIMEOUT   = 100;
  localparam int DEF_TMR_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_search_state(input state_e s);
    return (s == ST_LOAD) || (s == ST_WAIT) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/hash_wait_timer.sv
// Clearable, enabled up-counter with a terminal flag at TIMEOUT-1.
module hash_wait_timer
  import hash_nonce_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = DEF_TMR_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/hash_nonce_ctrl.sv
// Nonce-search controller: feeds {nonce, payload} blocks to the hash core,
// checks each digest against the target and reports the winning nonce.
//
// state | meaning
// IDLE  | no search yet; core parked via finished
// LOAD  | block registered, next pulse restarts the core
// WAIT  | waiting for hash_valid, timeout counter running
// CHECK | compare captured digest against target
// DONE  | result held, core parked; start re-arms
module hash_nonce_ctrl
  import hash_nonce_ctrl_pkg::*;
#(
  parameter int BYTE    = BYTE_BITS,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = DEF_TMR_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [PAYLOAD_BYTES*BYTE-1:0]             payload,
  input  logic [NONCE_BYTES*BYTE-1:0]               nonce_start,
  input  logic [BYTE-1:0]                           target,
  input  logic [DIGEST_BYTES*BYTE-1:0]              hash_h,
  input  logic                                      hash_valid,
  output logic [(NONCE_BYTES+PAYLOAD_BYTES)*BYTE-1:0] block,
  output logic                                      next,
  output logic                                      finished,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      found,
  output logic                                      error,
  output logic [NONCE_BYTES*BYTE-1:0]               nonce_out,
  output logic [DIGEST_BYTES*BYTE-1:0]              h_out
);

  localparam int NW = NONCE_BYTES * BYTE;
  localparam int PW = PAYLOAD_BYTES * BYTE;
  localparam int HW = DIGEST_BYTES * BYTE;
  localparam int BW = NW + PW;

  state_e          state_q, state_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [BYTE-1:0] target_q, target_d;
  logic [NW-1:0]   nonce_q, nonce_d;
  logic [HW-1:0]   h_q, h_d;
  logic [BW-1:0]   block_q, block_d;
  logic            found_q, found_d;
  logic            error_q, error_d;
  logic            done_q, done_d;
  logic [NW-1:0]   nonce_out_q, nonce_out_d;
  logic [HW-1:0]   h_out_q, h_out_d;

  logic            tmr_tc;
  logic            meet;
  logic [NW-1:0]   nonce_inc;

  hash_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_wait_timer (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (state_q == ST_LOAD),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (tmr_tc)
  );

  // Only the top two digest bytes take part in the difficulty test.
  assign meet      = (h_q[3*BYTE-1:2*BYTE] < target_q) && (h_q[2*BYTE-1:BYTE] < target_q);
  assign nonce_inc = nonce_q + NW'(1);

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    target_d    = target_q;
    nonce_d     = nonce_q;
    h_d         = h_q;
    block_d     = block_q;
    found_d     = found_q;
    error_d     = error_q;
    done_d      = 1'b0;
    nonce_out_d = nonce_out_q;
    h_out_d     = h_out_q;
    next        = 1'b0;
    finished    = 1'b0;
    busy        = is_search_state(state_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        finished = 1'b1;
        if (start) begin
          payload_d   = payload;
          target_d    = target;
          nonce_d     = nonce_start;
          block_d     = {nonce_start, payload};
          found_d     = 1'b0;
          error_d     = 1'b0;
          nonce_out_d = '0;
          h_out_d     = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        next    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hash_valid) begin
          h_d     = hash_h;
          state_d = ST_CHECK;
        end else if (tmr_tc) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (meet) begin
          found_d     = 1'b1;
          nonce_out_d = nonce_q;
          h_out_d     = h_q;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (&nonce_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          // Block is refreshed on entry to LOAD so it is valid alongside next.
          nonce_d = nonce_inc;
          block_d = {nonce_inc, payload_q};
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      payload_q   <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      h_q         <= '0;
      block_q     <= '0;
      found_q     <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      nonce_out_q <= '0;
      h_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      target_q    <= target_d;
      nonce_q     <= nonce_d;
      h_q         <= h_d;
      block_q     <= block_d;
      found_q     <= found_d;
      error_q     <= error_d;
      done_q      <= done_d;
      nonce_out_q <= nonce_out_d;
      h_out_q     <= h_out_d;
    end
  end

  assign block     = block_q;
  assign done      = done_q;
  assign found     = found_q;
  assign error     = error_q;
  assign nonce_out = nonce_out_q;
  assign h_out     = h_out_q;

endmodule

// File: tb/tb_hash_nonce_ctrl.sv
// Directed bench for hash_nonce_ctrl with a fixed-latency mock hash core.
module tb_hash_nonce_ctrl;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [95:0]  payload;
  logic [31:0]  nonce_start;
  logic [7:0]   target;
  logic [23:0]  hash_h = 24'h0;
  logic         hash_valid = 1'b0;
  logic [127:0] block;
  logic         next, finished, busy, done, found, error;
  logic [31:0]  nonce_out;
  logic [23:0]  h_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int cyc = 0, next_cnt = 0, done_cnt = 0, next_cyc = 0, done_cyc = 0;
  int mock_cnt = 0;
  int mock_lat = 72;
  bit mock_on = 1'b1;
  logic [31:0] mock_nonce = 32'h0;
  logic [31:0] mock_sel = 32'h0;
  logic [23:0] mock_h_sel = 24'h0;
  logic [23:0] mock_h_other = 24'h0;

  localparam logic [95:0] P1 = 96'h0123456789ABCDEF01234567;
  localparam logic [95:0] P2 = 96'hDEADBEEFCAFEF00D55AA33CC;
  localparam logic [95:0] P3 = 96'h111122223333444455556666;

  hash_nonce_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .payload     (payload),
    .nonce_start (nonce_start),
    .target      (target),
    .hash_h      (hash_h),
    .hash_valid  (hash_valid),
    .block       (block),
    .next        (next),
    .finished    (finished),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .error       (error),
    .nonce_out   (nonce_out),
    .h_out       (h_out)
  );

  always #5 clk = ~clk;

  // Mock core plus event monitor: valid arrives mock_lat cycles after next.
  always @(negedge clk) begin
    cyc++;
    hash_valid = 1'b0;
    if (mock_cnt > 0) begin
      mock_cnt--;
      if (mock_cnt == 0 && mock_on) begin
        hash_valid = 1'b1;
        hash_h = (mock_nonce == mock_sel) ? mock_h_sel : mock_h_other;
      end
    end
    if (next === 1'b1) begin
      next_cnt++;
      next_cyc   = cyc;
      mock_nonce = block[127:96];
      mock_cnt   = mock_lat;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish within time limit");
    $fatal(1);
  end

  task automatic start_search(input logic [95:0] p, input logic [31:0] n, input logic [7:0] t);
    @(negedge clk);
    payload = p; nonce_start = n; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int base_d;
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++; if (finished !== 1'b1) $display("FAIL rst_finished: got %b want 1", finished); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (next !== 1'b0) $display("FAIL rst_next: got %b want 0", next); else pass_cnt++;
    chk_cnt++; if ({done, found, error} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {done, found, error}); else pass_cnt++;
    chk_cnt++; if (block !== 128'h0) $display("FAIL rst_block: got %h want 0", block); else pass_cnt++;
    chk_cnt++; if ({nonce_out, h_out} !== 56'h0) $display("FAIL rst_result: got %h want 0", {nonce_out, h_out}); else pass_cnt++;
    reset = 1'b0;
    mock_lat = 72; mock_on = 1'b1;
    start_search(P1, 32'h0000_0010, 8'h10);
    repeat (20) @(negedge clk);
    #1;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else pass_cnt++;
    base_d = done_cnt;
    reset = 1'b1;
    #1;
    chk_cnt++; if (finished !== 1'b1) $display("FAIL rst_mid_finished: got %b want 1", finished); else pass_cnt++;
    chk_cnt++; if ({next, busy} !== 2'b00) $display("FAIL rst_mid_next_busy: got %b want 00", {next, busy}); else pass_cnt++;
    chk_cnt++; if (block !== 128'h0) $display("FAIL rst_mid_block: got %h want 0", block); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk_cnt++; if (done_cnt != base_d) $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - base_d); else pass_cnt++;
    chk_cnt++; if (finished !== 1'b1) $display("FAIL rst_idle_after: got %b want 1", finished); else pass_cnt++;
  endtask

  task automatic test_immediate_hit();
    int base_n, base_d;
    bit ok;
    @(negedge clk); #1;
    base_n = next_cnt; base_d = done_cnt;
    mock_lat = 72; mock_on = 1'b1;
    mock_sel = 32'h5; mock_h_sel = 24'h0A0BFF; mock_h_other = 24'hFFFFFF;
    start_search(P1, 32'h0000_0005, 8'h10);
    #1;
    chk_cnt++; if ({next, busy, finished} !== 3'b110) $display("FAIL hit_load_flags: got %b want 110", {next, busy, finished}); else pass_cnt++;
    chk_cnt++; if (block !== {32'h0000_0005, P1}) $display("FAIL hit_block: got %h want %h", block, {32'h0000_0005, P1}); else pass_cnt++;
    wait_done(200, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL hit_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if (found !== 1'b1) $display("FAIL hit_found: got %b want 1", found); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0) $display("FAIL hit_error: got %b want 0", error); else pass_cnt++;
    chk_cnt++; if (nonce_out !== 32'h5) $display("FAIL hit_nonce_out: got %h want 00000005", nonce_out); else pass_cnt++;
    chk_cnt++; if (h_out !== 24'h0A0BFF) $display("FAIL hit_h_out: got %h want 0a0bff", h_out); else pass_cnt++;
    chk_cnt++; if ({finished, busy} !== 2'b10) $display("FAIL hit_finished: got %b want 10", {finished, busy}); else pass_cnt++;
    chk_cnt++; if (done_cyc - next_cyc != 74) $display("FAIL hit_latency: got %0d want 74", done_cyc - next_cyc); else pass_cnt++;
    chk_cnt++; if (next_cnt - base_n != 1) $display("FAIL hit_next_count: got %0d want 1", next_cnt - base_n); else pass_cnt++;
    repeat (5) @(negedge clk);
    #1;
    chk_cnt++; if (done_cnt - base_d != 1) $display("FAIL hit_single_done: got %0d want 1", done_cnt - base_d); else pass_cnt++;
  endtask

  task automatic test_miss_then_hit();
    int base_n, base_d;
    bit ok;
    @(negedge clk); #1;
    base_n = next_cnt; base_d = done_cnt;
    mock_sel = 32'h0; mock_h_sel = 24'h20FF00; mock_h_other = 24'h0F0E00;
    start_search(P2, 32'h0000_0000, 8'h10);
    #1;
    chk_cnt++; if (found !== 1'b0) $display("FAIL mth_found_cleared: got %b want 0", found); else pass_cnt++;
    wait_done(400, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL mth_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if (next_cnt - base_n != 2) $display("FAIL mth_next_count: got %0d want 2", next_cnt - base_n); else pass_cnt++;
    chk_cnt++; if (mock_nonce !== 32'h1) $display("FAIL mth_second_nonce: got %h want 00000001", mock_nonce); else pass_cnt++;
    chk_cnt++; if (found !== 1'b1) $display("FAIL mth_found: got %b want 1", found); else pass_cnt++;
    chk_cnt++; if (nonce_out !== 32'h1) $display("FAIL mth_nonce_out: got %h want 00000001", nonce_out); else pass_cnt++;
    chk_cnt++; if (h_out !== 24'h0F0E00) $display("FAIL mth_h_out: got %h want 0f0e00", h_out); else pass_cnt++;
    chk_cnt++; if (block !== {32'h1, P2}) $display("FAIL mth_block: got %h want %h", block, {32'h1, P2}); else pass_cnt++;
    chk_cnt++; if (done_cyc - next_cyc != 74) $display("FAIL mth_latency: got %0d want 74", done_cyc - next_cyc); else pass_cnt++;
  endtask

  task automatic test_exhaustion();
    int base_n, base_d;
    bit ok;
    @(negedge clk); #1;
    base_n = next_cnt; base_d = done_cnt;
    mock_sel = 32'hFFFF_FFFE; mock_h_sel = 24'h000000; mock_h_other = 24'h000000;
    start_search(P3, 32'hFFFF_FFFE, 8'h00);
    wait_done(400, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL exh_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if (next_cnt - base_n != 2) $display("FAIL exh_next_count: got %0d want 2", next_cnt - base_n); else pass_cnt++;
    chk_cnt++; if ({found, error} !== 2'b00) $display("FAIL exh_flags: got %b want 00", {found, error}); else pass_cnt++;
    chk_cnt++; if (block !== {32'hFFFF_FFFF, P3}) $display("FAIL exh_block: got %h want %h", block, {32'hFFFF_FFFF, P3}); else pass_cnt++;
    chk_cnt++; if ({nonce_out, h_out} !== 56'h0) $display("FAIL exh_result: got %h want 0", {nonce_out, h_out}); else pass_cnt++;
    repeat (100) @(negedge clk);
    #1;
    chk_cnt++; if (next_cnt - base_n != 2) $display("FAIL exh_no_wrap: got %0d next pulses want 2", next_cnt - base_n); else pass_cnt++;
    chk_cnt++; if (done_cnt - base_d != 1) $display("FAIL exh_single_done: got %0d want 1", done_cnt - base_d); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base_n, base_d;
    bit ok;
    @(negedge clk); #1;
    base_n = next_cnt; base_d = done_cnt;
    mock_on = 1'b0;
    start_search(P1, 32'h0000_0077, 8'h10);
    wait_done(300, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL to_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if (done_cyc - next_cyc != 101) $display("FAIL to_latency: got %0d want 101", done_cyc - next_cyc); else pass_cnt++;
    chk_cnt++; if ({error, found} !== 2'b10) $display("FAIL to_flags: got %b want 10", {error, found}); else pass_cnt++;
    chk_cnt++; if (next_cnt - base_n != 1) $display("FAIL to_next_count: got %0d want 1", next_cnt - base_n); else pass_cnt++;

    base_d = done_cnt;
    mock_on = 1'b1; mock_lat = 100;
    mock_sel = 32'h78; mock_h_sel = 24'h010100; mock_h_other = 24'hFFFFFF;
    start_search(P1, 32'h0000_0078, 8'h10);
    #1;
    chk_cnt++; if (error !== 1'b0) $display("FAIL to_error_cleared: got %b want 0", error); else pass_cnt++;
    wait_done(300, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL to_edge_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if ({error, found} !== 2'b01) $display("FAIL to_edge_flags: got %b want 01", {error, found}); else pass_cnt++;
    chk_cnt++; if (nonce_out !== 32'h78) $display("FAIL to_edge_nonce: got %h want 00000078", nonce_out); else pass_cnt++;
    chk_cnt++; if (done_cyc - next_cyc != 102) $display("FAIL to_edge_latency: got %0d want 102", done_cyc - next_cyc); else pass_cnt++;
    mock_lat = 72;
  endtask

  task automatic test_start_while_busy();
    int base_n, base_d;
    bit ok;
    @(negedge clk); #1;
    base_n = next_cnt; base_d = done_cnt;
    mock_sel = 32'h100; mock_h_sel = 24'h050500; mock_h_other = 24'hFFFFFF;
    start_search(P1, 32'h0000_0100, 8'h10);
    repeat (10) @(negedge clk);
    payload = P2; nonce_start = 32'h0000_0999; target = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk_cnt++; if (block !== {32'h100, P1}) $display("FAIL swb_block: got %h want %h", block, {32'h100, P1}); else pass_cnt++;
    chk_cnt++; if ({busy, next} !== 2'b10) $display("FAIL swb_state: got %b want 10", {busy, next}); else pass_cnt++;
    wait_done(200, base_d, ok);
    chk_cnt++; if (!ok) $display("FAIL swb_done_seen: got no done want done"); else pass_cnt++;
    chk_cnt++; if (found !== 1'b1) $display("FAIL swb_found: got %b want 1", found); else pass_cnt++;
    chk_cnt++; if (nonce_out !== 32'h100) $display("FAIL swb_nonce_out: got %h want 00000100", nonce_out); else pass_cnt++;
    chk_cnt++; if (h_out !== 24'h050500) $display("FAIL swb_h_out: got %h want 050500", h_out); else pass_cnt++;
    chk_cnt++; if (next_cnt - base_n != 1) $display("FAIL swb_next_count: got %0d want 1", next_cnt - base_n); else pass_cnt++;
    chk_cnt++; if (block !== {32'h100, P1}) $display("FAIL swb_block_end: got %h want %h", block, {32'h100, P1}); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    payload = '0;
    nonce_start = '0;
    target = '0;
    test_reset();
    test_immediate_hit();
    test_miss_then_hit();
    test_exhaustion();
    test_timeout();
    test_start_while_busy();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
